// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared FSM encoding and default sizing for the serializer
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIV   = 4;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - bit-rate prescaler, one tick every DIV enabled cycles
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_EN,
  output logic o_TICK
);

  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // count 0..DIV-1 while enabled; held at 0 otherwise so every word starts aligned
  always_ff @(posedge i_CLK) begin
    if (i_RST || !i_EN) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_TICK = i_EN && (cnt == LAST);

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter, MSB first with shift strobe
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIV   = DEF_DIV
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic [WIDTH-1:0] i_DATA,
  input  logic             i_VALID,
  output logic             o_READY,
  output logic             o_SDO,
  output logic             o_SFT,
  output logic             o_BUSY,
  output logic             o_DONE
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             tick;

  tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .i_CLK  (i_CLK),
    .i_RST  (i_RST),
    .i_EN   (state == SHIFT),
    .o_TICK (tick)
  );

  // word FSM: load on accept, shift on each tick, one-cycle DONE before going idle
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      o_READY <= 1'b1;
      o_BUSY  <= 1'b0;
      o_DONE  <= 1'b0;
    end else begin
      o_DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (i_VALID) begin
            shreg   <= i_DATA;
            bit_cnt <= '0;
            state   <= SHIFT;
            o_READY <= 1'b0;
            o_BUSY  <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state  <= DONE;
              o_DONE <= 1'b1;
            end
          end
        end
        DONE: begin
          state   <= IDLE;
          o_READY <= 1'b1;
          o_BUSY  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          o_READY <= 1'b1;
          o_BUSY  <= 1'b0;
        end
      endcase
    end
  end

  // the data line only carries the word while shifting; it is low in IDLE and DONE
  assign o_SDO = (state == SHIFT) && shreg[WIDTH-1];
  assign o_SFT = tick;

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - randomized and directed checks of piso_tx against a cycle-position model
module tb_piso_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data  [2];
  logic         valid [2];
  logic         ready [2];
  logic         sdo   [2];
  logic         sft   [2];
  logic         busy  [2];
  logic         done  [2];
  logic [W-1:0] sipo;
  bit           chk_en = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(W), .DIV(4)) dut4 (
    .i_CLK(clk), .i_RST(rst), .i_DATA(data[0]), .i_VALID(valid[0]),
    .o_READY(ready[0]), .o_SDO(sdo[0]), .o_SFT(sft[0]), .o_BUSY(busy[0]), .o_DONE(done[0])
  );

  piso_tx #(.WIDTH(W), .DIV(1)) dut1 (
    .i_CLK(clk), .i_RST(rst), .i_DATA(data[1]), .i_VALID(valid[1]),
    .o_READY(ready[1]), .o_SDO(sdo[1]), .o_SFT(sft[1]), .o_BUSY(busy[1]), .o_DONE(done[1])
  );

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // downstream SIPO fed by the DIV=4 instance
  always @(posedge clk) begin
    if (sft[0]) sipo <= {sipo[W-2:0], sdo[0]};
  end

  // model: per instance, whether a word is in flight and how many cycles since its accept edge
  bit           m_act [2] = '{1'b0, 1'b0};
  int           m_c   [2] = '{0, 0};
  logic [W-1:0] m_w   [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_act[i] = 1'b0;
      end else if (!m_act[i]) begin
        if (valid[i]) begin
          m_act[i] = 1'b1;
          m_c[i]   = 1;
          m_w[i]   = data[i];
        end
      end else if (m_c[i] == W * div_of(i) + 1) begin
        m_act[i] = 1'b0;
      end else begin
        m_c[i] = m_c[i] + 1;
      end
    end
  end

  // every cycle: outputs {ready,busy,sdo,sft,done} follow from the cycle position in the word
  always @(negedge clk) begin : cmp
    logic [4:0] e;
    logic [4:0] a;
    int d;
    int bi;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        d = div_of(i);
        if (!m_act[i]) begin
          e = 5'b10000;
        end else if (m_c[i] <= W * d) begin
          bi = W - 1 - (m_c[i] - 1) / d;
          e  = {1'b0, 1'b1, m_w[i][bi], ((m_c[i] % d) == 0), 1'b0};
        end else begin
          e = 5'b01001;
        end
        a = {ready[i], busy[i], sdo[i], sft[i], done[i]};
        check($sformatf("cycle dut_div%0d rdy/bsy/sdo/sft/done", d), {27'b0, a}, {27'b0, e});
      end
    end
  end

  // one word on instance sel, observed cycle by cycle with the accept edge as cycle 0
  task automatic xfer(input int sel, input logic [7:0] w, input int rst_at,
                      input int rej_lo, input int rej_hi,
                      output logic [7:0] bits, output int first_s, output int last_s,
                      output int n_s, output int done_c, output int ready_c, output int late);
    int d;
    d = div_of(sel);
    bits = '0; first_s = 0; last_s = 0; n_s = 0; done_c = 0; ready_c = 0; late = 0;
    data[sel]  = w;
    valid[sel] = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= W * d + 4; k++) begin
      rst = (k == rst_at);
      if (k >= rej_lo && k <= rej_hi) begin
        valid[sel] = 1'b1;
        data[sel]  = 8'h55;
      end else begin
        valid[sel] = 1'b0;
      end
      @(negedge clk);
      if (sft[sel]) begin
        n_s++;
        if (first_s == 0) first_s = k;
        last_s = k;
        bits = {bits[6:0], sdo[sel]};
      end
      if (done[sel]) done_c = k;
      if (ready[sel] && ready_c == 0) ready_c = k;
      if (rst_at > 0 && k > rst_at && (sft[sel] || done[sel])) late++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    valid[sel] = 1'b0;
  endtask

  task automatic loopback();
    logic [7:0] words [3];
    int idx;
    int rc [3];
    words = '{8'h00, 8'hFF, 8'h81};
    rc = '{0, 0, 0};
    idx = 0;
    data[0]  = words[0];
    valid[0] = 1'b1;
    for (int k = 0; k < 150 && idx < 3; k++) begin
      @(negedge clk);
      if (ready[0] && idx > 0) rc[idx]++;
      if (done[0]) begin
        check($sformatf("loopback sipo word %0d", idx), {24'b0, sipo}, {24'b0, words[idx]});
        idx++;
        if (idx < 3) data[0] = words[idx];
        else valid[0] = 1'b0;
      end
    end
    check("loopback words delivered", idx, 3);
    check("loopback ready gap 1", rc[1], 1);
    check("loopback ready gap 2", rc[2], 1);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] bits;
    int fs, ls, ns, dc, rc, lt;

    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      valid[i] = 1'b0;
      data[i]  = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset outputs div4", {27'b0, ready[0], busy[0], sdo[0], sft[0], done[0]}, 32'h10);
    check("reset outputs div1", {27'b0, ready[1], busy[1], sdo[1], sft[1], done[1]}, 32'h10);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    xfer(0, 8'hA5, 0, 0, 0, bits, fs, ls, ns, dc, rc, lt);
    check("a5 serial bits", {24'b0, bits}, 32'hA5);
    check("a5 first strobe cycle", fs, 4);
    check("a5 last strobe cycle", ls, 32);
    check("a5 strobe count", ns, 8);
    check("a5 done cycle", dc, 33);
    check("a5 ready cycle", rc, 34);

    xfer(1, 8'h3C, 0, 0, 0, bits, fs, ls, ns, dc, rc, lt);
    check("3c serial bits", {24'b0, bits}, 32'h3C);
    check("3c first strobe cycle", fs, 1);
    check("3c last strobe cycle", ls, 8);
    check("3c strobe count", ns, 8);
    check("3c done cycle", dc, 9);

    xfer(0, 8'hF0, 14, 0, 0, bits, fs, ls, ns, dc, rc, lt);
    check("abort strobes before reset", ns, 3);
    check("abort activity after reset", lt, 0);
    check("abort done never", dc, 0);
    check("abort ready cycle", rc, 15);

    xfer(0, 8'hAA, 0, 5, 20, bits, fs, ls, ns, dc, rc, lt);
    check("busy reject bits", {24'b0, bits}, 32'hAA);
    check("busy reject done cycle", dc, 33);

    loopback();

    rst      = 1'b1;
    valid[0] = 1'b1;
    data[0]  = 8'h99;
    @(posedge clk); #1;
    rst      = 1'b0;
    valid[0] = 1'b0;
    @(negedge clk);
    check("reset beats valid busy", {31'b0, busy[0]}, 32'h0);
    check("reset beats valid ready", {31'b0, ready[0]}, 32'h1);
    @(posedge clk); #1;

    repeat (3000) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < 2; i++) begin
        valid[i] = ($urandom_range(0, 2) != 0);
        data[i]  = 8'($urandom);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) valid[i] = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, 8, word length in bits; the legal range is 2..32.
REQ-002 Parameter DIV, 4, number of clock cycles per bit; the legal range is 1..2^16.
REQ-003 i_CLK  input  1  single clock; all logic is on the rising edge.
REQ-004 i_RST  input  1  reset, synchronous and active-high.
REQ-005 i_DATA  input  WIDTH  parallel word to be serialized.
REQ-006 i_VALID  input  1  i_DATA is valid this cycle.
REQ-007 o_READY  output  1  block can accept a word this cycle.
REQ-008 o_SDO  output  1  serial data out, MSB first, feeds the downstream SIPO data input.
REQ-009 o_SFT  output  1  one-cycle shift strobe, feeds the downstream SIPO shift input.
REQ-010 o_BUSY  output  1  a transfer is in progress.
REQ-011 o_DONE  output  1  one-cycle pulse that marks the end of a word.

Function
REQ-012 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE: o_READY=1, o_BUSY=0, o_SDO=0 and o_SFT=0.
REQ-014 IDLE to SHIFT: the transition SHALL occur on an edge where i_VALID=1 and o_READY=1; at that edge i_DATA is loaded into the shift register, the bit counter is set to 0 and the prescaler is set to 0.
REQ-015 SHIFT: o_READY=0, o_BUSY=1, and o_SDO=shreg[WIDTH-1] combinationally at all times.
REQ-016 Prescaler: the prescaler SHALL count 0..DIV-1 while in SHIFT; o_SFT=1 in exactly the cycle where the count equals DIV-1, and the count wraps to 0.
REQ-017 o_SDO SHALL be stable throughout every cycle in which o_SFT=1.
REQ-018 On the edge that ends an o_SFT cycle, the block SHALL shift shreg left by 1 with a 0 fill and increment the bit counter.
REQ-019 After the WIDTH-th strobe the FSM SHALL go to DONE.
REQ-020 DONE SHALL last exactly 1 cycle, with o_DONE=1, o_BUSY=1, o_READY=0 and o_SDO=0; the FSM then returns to IDLE.
REQ-021 Latency: with the accept edge as cycle 0, strobes SHALL occur in cycles k*DIV for k=1..WIDTH, o_DONE in cycle WIDTH*DIV+1, and o_READY=1 again in cycle WIDTH*DIV+2.
REQ-022 DIV=1: o_SFT SHALL be high in every SHIFT cycle, giving back-to-back bits.
REQ-023 i_VALID asserted while o_READY=0 SHALL be ignored; i_DATA SHALL NOT be sampled outside the accept edge.
REQ-024 Holding i_VALID high continuously SHALL produce back-to-back words with exactly one IDLE cycle between o_DONE and the next accept.
REQ-025 The bit counter SHALL be $clog2(WIDTH+1) bits wide and the prescaler $clog2(DIV+1) bits wide; neither counter may wrap in an unintended way.

Reset
REQ-026 i_RST=1 at a clock edge SHALL force IDLE, shreg=0, bit counter=0 and prescaler=0 from that edge onward.
REQ-027 Reset output values SHALL be o_READY=1, o_BUSY=0, o_SDO=0, o_SFT=0 and o_DONE=0.
REQ-028 Reset asserted mid-word SHALL abort the transfer with no further o_SFT and no o_DONE; the partial word is discarded.
REQ-029 If i_RST and i_VALID are both 1 on the same edge, reset SHALL win and the word is not accepted.

Structure
REQ-030 The shared package piso_pkg SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH/DIV constants.
REQ-031 The prescaler SHALL be a sub-module tick_gen, with inputs clock, reset and enable, parameter DIV, and output tick; piso_tx instantiates it with enable=(state==SHIFT).

Verification
REQ-032 Reset, then WIDTH=8, DIV=4, i_DATA=8'hA5 with i_VALID for one cycle -> o_SDO at the 8 strobes = 1,0,1,0,0,1,0,1; strobes in cycles 4,8,...,32; o_DONE in cycle 33; o_READY in cycle 34.
REQ-033 DIV=1, 8'h3C -> o_SFT high in cycles 1..8 with o_SDO=0,0,1,1,1,1,0,0; o_DONE in cycle 9.
REQ-034 Loopback: connect o_SDO/o_SFT to a SIPO and send 8'h00, 8'hFF, 8'h81 back-to-back with i_VALID held high -> the SIPO holds each word at its o_DONE, and o_READY is high for exactly one cycle between words.
REQ-035 Reset mid-word: i_RST=1 for one cycle at cycle 14 of an 8'hF0 transfer (DIV=4) -> no o_SFT and no o_DONE afterwards; o_READY=1 from cycle 15.
REQ-036 Busy rejection: i_DATA=8'h55 with i_VALID=1 during SHIFT of 8'hAA -> the 8'hAA serializes unchanged and 8'h55 is not transmitted unless i_VALID is still high in IDLE.
REQ-037 Simultaneous events: i_RST=1 and i_VALID=1 on the same edge -> the block stays in IDLE with o_BUSY=0 on the following cycle.
